// File: rtl/audio_source_arbiter.sv
// Three-source audio arbiter: once per frame, picks the highest-priority requester,
// attenuates its stereo sample and presents it registered to the speaker controller.
// Every change of owner is separated by one silent frame to avoid clicks.
module audio_source_arbiter #(
    parameter int unsigned FRAME_CLKS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  i_req,
    input  logic [47:0] i_src_left,
    input  logic [47:0] i_src_right,
    input  logic [2:0]  i_vol,
    output logic [2:0]  o_grant,
    output logic [2:0]  o_sample_ack,
    output logic [15:0] o_audio_in_left,
    output logic [15:0] o_audio_in_right,
    output logic        o_frame_tick,
    output logic        o_busy
);

    localparam int unsigned CW = $clog2(FRAME_CLKS);

    typedef enum logic [1:0] {
        StIdle,
        StOwn,
        StSwitch
    } state_e;

    logic [CW-1:0] r_cnt;
    logic          r_tick;
    state_e        r_state;
    logic [1:0]    r_owner;
    logic [2:0]    r_grant;
    logic [2:0]    r_ack;
    logic [15:0]   r_left;
    logic [15:0]   r_right;

    state_e        w_state_d;
    logic [1:0]    w_owner_d;
    logic [2:0]    w_grant_d;
    logic [2:0]    w_ack_d;
    logic [15:0]   w_left_d;
    logic [15:0]   w_right_d;

    logic          w_win_valid;
    logic [1:0]    w_win_idx;
    logic signed [15:0] w_sel_left;
    logic signed [15:0] w_sel_right;
    logic signed [15:0] w_scaled_left;
    logic signed [15:0] w_scaled_right;
    logic          w_take;
    logic          w_silence;

    // Frame counter and registered tick; the tick is set one cycle early so it is
    // high exactly while the counter sits at FRAME_CLKS-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= r_cnt + CW'(1);
            r_tick <= (r_cnt == CW'(FRAME_CLKS - 2));
        end
    end

    // Priority encoder: highest-index requester wins.
    always_comb begin
        w_win_valid = |i_req;
        w_win_idx   = 2'd0;
        if (i_req[2]) begin
            w_win_idx = 2'd2;
        end else if (i_req[1]) begin
            w_win_idx = 2'd1;
        end
    end

    // Select the winner's sample pair and apply the arithmetic attenuation.
    always_comb begin
        w_sel_left  = i_src_left[15:0];
        w_sel_right = i_src_right[15:0];
        unique case (w_win_idx)
            2'd1: begin
                w_sel_left  = i_src_left[31:16];
                w_sel_right = i_src_right[31:16];
            end
            2'd2: begin
                w_sel_left  = i_src_left[47:32];
                w_sel_right = i_src_right[47:32];
            end
            default: begin
                w_sel_left  = i_src_left[15:0];
                w_sel_right = i_src_right[15:0];
            end
        endcase
        w_scaled_left  = w_sel_left >>> i_vol;
        w_scaled_right = w_sel_right >>> i_vol;
    end

    // Next-state and next-output logic; everything holds except at tick, ack defaults low.
    always_comb begin
        w_state_d = r_state;
        w_owner_d = r_owner;
        w_grant_d = r_grant;
        w_ack_d   = 3'b000;
        w_left_d  = r_left;
        w_right_d = r_right;
        w_take    = 1'b0;
        w_silence = 1'b0;

        if (r_tick) begin
            unique case (r_state)
                StIdle: begin
                    w_take = w_win_valid;
                end
                StOwn: begin
                    if (!w_win_valid) begin
                        w_silence = 1'b1;
                        w_state_d = StIdle;
                    end else if (w_win_idx == r_owner) begin
                        w_take = 1'b1;
                    end else begin
                        w_silence = 1'b1;
                        w_state_d = StSwitch;
                    end
                end
                StSwitch: begin
                    if (w_win_valid) begin
                        w_take = 1'b1;
                    end else begin
                        w_silence = 1'b1;
                        w_state_d = StIdle;
                    end
                end
                default: begin
                    w_silence = 1'b1;
                    w_state_d = StIdle;
                end
            endcase
        end

        if (w_take) begin
            w_state_d = StOwn;
            w_owner_d = w_win_idx;
            w_grant_d = 3'b001 << w_win_idx;
            w_ack_d   = 3'b001 << w_win_idx;
            w_left_d  = w_scaled_left;
            w_right_d = w_scaled_right;
        end else if (w_silence) begin
            w_grant_d = 3'b000;
            w_left_d  = 16'h0000;
            w_right_d = 16'h0000;
        end
    end

    // State and registered output update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_owner <= 2'd0;
            r_grant <= 3'b000;
            r_ack   <= 3'b000;
            r_left  <= 16'h0000;
            r_right <= 16'h0000;
        end else begin
            r_state <= w_state_d;
            r_owner <= w_owner_d;
            r_grant <= w_grant_d;
            r_ack   <= w_ack_d;
            r_left  <= w_left_d;
            r_right <= w_right_d;
        end
    end

    assign o_grant          = r_grant;
    assign o_sample_ack     = r_ack;
    assign o_audio_in_left  = r_left;
    assign o_audio_in_right = r_right;
    assign o_frame_tick     = r_tick;
    assign o_busy           = (r_state != StIdle);

endmodule
